// File: rtl/fwnoc_pkg.sv
// Shared fwnoc definitions: flit width, header field positions and the output-arbiter state encoding.
package fwnoc_pkg;
   localparam int FLIT_WIDTH    = 32;
   localparam int HDR_DEST_MSB  = 31;
   localparam int HDR_DEST_LSB  = 28;
   localparam int HDR_SRC_MSB   = 27;
   localparam int HDR_SRC_LSB   = 24;
   localparam int HDR_LEN_MSB   = 7;
   localparam int HDR_LEN_LSB   = 0;
   localparam int HDR_LEN_WIDTH = HDR_LEN_MSB - HDR_LEN_LSB + 1;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_HDR  = 2'd1,
      ARB_BODY = 2'd2
   } arb_state_e;

   function automatic logic [HDR_LEN_WIDTH-1:0] hdr_len(input logic [FLIT_WIDTH-1:0] flit);
      return flit[HDR_LEN_MSB:HDR_LEN_LSB];
   endfunction
endpackage

// File: rtl/fwnoc_rr_pick.sv
// Combinational round-robin picker: first requester at or after (last+1) mod N, wrapping modulo N
// (not 2^IW), so non-power-of-2 port counts are handled.
module fwnoc_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          found,
   output logic [IW-1:0] idx
);
   function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N) begin
         s = s - N;
      end else begin
         s = s;
      end
      return IW'(s);
   endfunction

   logic [IW-1:0] cand;

   // Scan from the farthest candidate back to the nearest so the nearest requester wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         cand  = wrap_idx(last, i + 1);
         found = found | req[cand];
         idx   = req[cand] ? cand : idx;
      end
   end
endmodule

// File: rtl/fwnoc_out_arb.sv
// Per-output packet arbiter: round-robin grant locked from header to last payload flit.
// Optional FWNOC_OUT_ARB_OUTREG_EN inserts a 2-entry skid slice in front of the e_ port.
module fwnoc_out_arb
   import fwnoc_pkg::*;
#(
   parameter int N_PORTS     = 4,
   parameter int GRANT_WIDTH = $clog2(N_PORTS)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [N_PORTS-1:0]            i_valid,
   input  logic [FLIT_WIDTH*N_PORTS-1:0] i_dat,
   output logic [N_PORTS-1:0]            i_ready,
   output logic                          e_valid,
   output logic [FLIT_WIDTH-1:0]         e_dat,
   input  logic                          e_ready
);
   arb_state_e               state, state_n;
   logic [GRANT_WIDTH-1:0]   grant, grant_n, last, last_n, pick;
   logic [HDR_LEN_WIDTH-1:0] remain, remain_n;
   logic                     found, mux_valid, mux_ready, xfer;
   logic [FLIT_WIDTH-1:0]    mux_dat;

   fwnoc_rr_pick #(.N(N_PORTS), .IW(GRANT_WIDTH)) u_pick (
      .req   (i_valid),
      .last  (last),
      .found (found),
      .idx   (pick)
   );

   // Route the granted input to the output side while a packet is locked.
   always_comb begin
      mux_valid = 1'b0;
      mux_dat   = '0;
      i_ready   = '0;
      if (state != ARB_IDLE) begin
         mux_valid      = i_valid[grant];
         mux_dat        = i_dat[int'(grant)*FLIT_WIDTH +: FLIT_WIDTH];
         i_ready[grant] = mux_ready;
      end else begin
         mux_valid = 1'b0;
      end
   end

   assign xfer = mux_valid & mux_ready;

   // Next-state: arbitrate in IDLE, then follow the header length to the last payload flit.
   always_comb begin
      state_n  = state;
      grant_n  = grant;
      last_n   = last;
      remain_n = remain;
      case (state)
         ARB_IDLE: begin
            if (found) begin
               state_n = ARB_HDR;
               grant_n = pick;
               last_n  = pick;
            end else begin
               state_n = ARB_IDLE;
            end
         end
         ARB_HDR: begin
            if (xfer) begin
               if (hdr_len(mux_dat) == 8'd0) begin
                  state_n = ARB_IDLE;
               end else begin
                  remain_n = hdr_len(mux_dat);
                  state_n  = ARB_BODY;
               end
            end else begin
               state_n = ARB_HDR;
            end
         end
         ARB_BODY: begin
            if (xfer) begin
               remain_n = remain - 8'd1;
               state_n  = (remain == 8'd1) ? ARB_IDLE : ARB_BODY;
            end else begin
               state_n = ARB_BODY;
            end
         end
         default: state_n = ARB_IDLE;
      endcase
   end

   // Arbiter state register; last starts at N_PORTS-1 so input 0 wins first.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= ARB_IDLE;
         grant  <= '0;
         last   <= GRANT_WIDTH'(N_PORTS - 1);
         remain <= 8'd0;
      end else begin
         state  <= state_n;
         grant  <= grant_n;
         last   <= last_n;
         remain <= remain_n;
      end
   end

`ifdef FWNOC_OUT_ARB_OUTREG_EN
   logic [FLIT_WIDTH-1:0] skid_mem [2];
   logic                  skid_wr, skid_rd, skid_pop;
   logic [1:0]            skid_cnt;

   // Ready toward the mux depends only on slice occupancy, cutting the e_ready path.
   assign mux_ready = (skid_cnt != 2'd2);
   assign e_valid   = (skid_cnt != 2'd0);
   assign e_dat     = skid_mem[skid_rd];
   assign skid_pop  = e_valid & e_ready;

   // Two-entry slice: write on mux transfers, read on output transfers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         skid_mem[0] <= '0;
         skid_mem[1] <= '0;
         skid_wr     <= 1'b0;
         skid_rd     <= 1'b0;
         skid_cnt    <= 2'd0;
      end else begin
         if (xfer) begin
            skid_mem[skid_wr] <= mux_dat;
            skid_wr           <= ~skid_wr;
         end
         if (skid_pop) begin
            skid_rd <= ~skid_rd;
         end
         skid_cnt <= skid_cnt + {1'b0, xfer} - {1'b0, skid_pop};
      end
   end
`else
   assign mux_ready = e_ready;
   assign e_valid   = mux_valid;
   assign e_dat     = mux_dat;
`endif
endmodule
